// File: rtl/lbp_host_mem.sv
// Host-side memory model for the LBP engine.
// Loads a gray image from a pixel stream, serves the engine's zero-latency
// reads, captures LBP results and checks write order, count and protocol.
//
// state | meaning
// ------+------------------------------------------------------------
// LOAD  | accepting image pixels in raster order; engine traffic is an error
// SERVE | image ready; serving reads and capturing LBP writes
// DONE  | finish seen; reads still served, writes rejected as errors
module lbp_host_mem #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int NPIX   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  output logic              seq_err,
  output logic              proto_err,
  output logic              incomplete,
  input  logic [ADDR_W-1:0] res_addr,
  output logic [DATA_W-1:0] res_data
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
  localparam logic [ADDR_W:0]   NPIX_CNT = (ADDR_W+1)'(NPIX);
  localparam logic [ADDR_W:0]   CNT_MAX  = '1;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {S_LOAD, S_SERVE, S_DONE} state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] gray_mem [NPIX];
  logic [DATA_W-1:0] lbp_mem  [NPIX];

  logic [ADDR_W-1:0] ld_cnt;
  logic [ADDR_W-1:0] exp_addr;
  logic [ADDR_W:0]   wr_cnt_inc;
  logic [ADDR_W:0]   wr_cnt_fin;

  // Saturating write count, and the count including a write in this cycle
  // (used when finish and the last write coincide).
  always_comb begin
    wr_cnt_inc = (wr_cnt == CNT_MAX) ? wr_cnt : wr_cnt + CNT_ONE;
    wr_cnt_fin = lbp_valid ? wr_cnt_inc : wr_cnt;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= state_nxt;
  end

  // Next-state logic and state-decoded handshakes.
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    case (state)
      S_LOAD: begin
        load_ready = 1'b1;
        if (load_valid && ld_cnt == LAST_PIX) state_nxt = S_SERVE;
      end
      S_SERVE: begin
        gray_ready = 1'b1;
        if (finish) state_nxt = S_DONE;
      end
      S_DONE: begin
        gray_ready = 1'b1;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  // Zero-latency gray read port; idle value is zero.
  always_comb begin
    gray_data = '0;
    if (state != S_LOAD && gray_req) gray_data = gray_mem[gray_addr];
  end

  // Memory arrays are not reset; contents survive a reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_valid)  gray_mem[ld_cnt]  <= load_data;
    if (state == S_SERVE && lbp_valid)  lbp_mem[lbp_addr] <= lbp_data;
  end

  // Counters, sticky flags and registered result readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_cnt     <= '0;
      exp_addr   <= '0;
      wr_cnt     <= '0;
      done       <= 1'b0;
      seq_err    <= 1'b0;
      proto_err  <= 1'b0;
      incomplete <= 1'b0;
      res_data   <= '0;
    end else begin
      res_data <= lbp_mem[res_addr];
      case (state)
        S_LOAD: begin
          if (load_valid) ld_cnt <= ld_cnt + ADDR_W'(1);
          if (lbp_valid || finish || gray_req) proto_err <= 1'b1;
        end
        S_SERVE: begin
          if (lbp_valid) begin
            wr_cnt   <= wr_cnt_inc;
            // Resynchronise on the engine's address so one skip flags once.
            exp_addr <= lbp_addr + ADDR_W'(1);
            if (lbp_addr != exp_addr) seq_err <= 1'b1;
          end
          if (finish) begin
            done       <= 1'b1;
            incomplete <= (wr_cnt_fin != NPIX_CNT);
          end
        end
        S_DONE: begin
          if (lbp_valid) proto_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_host_mem.sv
// Directed bench for lbp_host_mem with a readback scoreboard and an
// independent model of the result memory.
module tb_lbp_host_mem;

  localparam int NPIX = 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_ready;
  logic        gray_ready;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        done;
  logic [14:0] wr_cnt;
  logic        seq_err;
  logic        proto_err;
  logic        incomplete;
  logic [13:0] res_addr;
  logic [7:0]  res_data;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic [7:0]  model [NPIX];

  lbp_host_mem dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .gray_ready(gray_ready), .gray_req(gray_req), .gray_addr(gray_addr),
    .gray_data(gray_data),
    .lbp_valid(lbp_valid), .lbp_addr(lbp_addr), .lbp_data(lbp_data),
    .finish(finish), .done(done), .wr_cnt(wr_cnt), .seq_err(seq_err),
    .proto_err(proto_err), .incomplete(incomplete),
    .res_addr(res_addr), .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_empty: got 0x%0h, expected an entry", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic load_image(input int stall_pix);
    for (int i = 0; i < NPIX; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0];
      tick();
      if (i < stall_pix) begin
        load_valid = 1'b0;
        load_data  = 8'hA5;
        tick();
      end
    end
    load_valid = 1'b0;
  endtask

  task automatic write_px(input int a, input logic fin);
    lbp_valid = 1'b1;
    lbp_addr  = a[13:0];
    lbp_data  = ~a[7:0];
    finish    = fin;
    model[a]  = ~a[7:0];
    tick();
    lbp_valid = 1'b0;
    finish    = 1'b0;
  endtask

  task automatic readback(input string tag, input int a);
    res_addr = a[13:0];
    push(tag, 32'(model[a]));
    tick();
    pop_check(32'(res_data));
  endtask

  task automatic gray_read(input string tag, input logic req, input int a, input logic [7:0] exp);
    gray_req  = req;
    gray_addr = a[13:0];
    push(tag, 32'(exp));
    #1;
    pop_check(32'(gray_data));
    gray_req = 1'b0;
  endtask

  task automatic check_all_clear(input string pfx);
    check({pfx, "_load_ready"}, 32'(load_ready), 32'd1);
    check({pfx, "_gray_ready"}, 32'(gray_ready), 32'd0);
    check({pfx, "_done"},       32'(done),       32'd0);
    check({pfx, "_seq_err"},    32'(seq_err),    32'd0);
    check({pfx, "_proto_err"},  32'(proto_err),  32'd0);
    check({pfx, "_incomplete"}, 32'(incomplete), 32'd0);
    check({pfx, "_wr_cnt"},     32'(wr_cnt),     32'd0);
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_data = '0;
    gray_req = 1'b0; gray_addr = '0;
    lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0;
    finish = 1'b0; res_addr = '0;
    repeat (3) tick();
    check_all_clear("rst");
    check("rst_gray_data", 32'(gray_data), 32'd0);
    check("rst_res_data",  32'(res_data),  32'd0);
    reset = 1'b0;
    tick();

    // Engine traffic while loading: flagged, not counted, stays in LOAD.
    gray_read("load_gray_data", 1'b1, 16'h0105, 8'h00);
    lbp_valid = 1'b1; lbp_addr = '0; lbp_data = 8'h55;
    tick();
    lbp_valid = 1'b0; finish = 1'b1;
    tick();
    finish = 1'b0;
    check("load_proto_err",  32'(proto_err),  32'd1);
    check("load_wr_cnt",     32'(wr_cnt),     32'd0);
    check("load_load_ready", 32'(load_ready), 32'd1);
    check("load_gray_ready", 32'(gray_ready), 32'd0);
    check("load_done",       32'(done),       32'd0);

    // Image load with stalls; gray_ready only on the last accept.
    for (int i = 0; i < NPIX; i++) begin
      load_valid = 1'b1;
      load_data  = i[7:0];
      tick();
      if (i == 0)         check("ld_first_gray_ready", 32'(gray_ready), 32'd0);
      if (i == NPIX - 2)  check("ld_penult_gray_ready", 32'(gray_ready), 32'd0);
      if (i == NPIX - 1) begin
        check("ld_last_gray_ready", 32'(gray_ready), 32'd1);
        check("ld_last_load_ready", 32'(load_ready), 32'd0);
      end
      if (i < 4096) begin
        load_valid = 1'b0;
        load_data  = 8'hA5;
        tick();
        if (i == 100) check("ld_stall_gray_ready", 32'(gray_ready), 32'd0);
      end
    end
    load_valid = 1'b0;

    gray_read("gray_0105",     1'b1, 16'h0105, 8'h05);
    gray_read("gray_noreq",    1'b0, 16'h0105, 8'h00);
    gray_read("gray_3fff",     1'b1, 16'h3FFF, 8'hFF);

    // A few writes, then reset in the middle of serving.
    for (int a = 0; a < 10; a++) write_px(a, 1'b0);
    check("mid_wr_cnt",  32'(wr_cnt),  32'd10);
    check("mid_seq_err", 32'(seq_err), 32'd0);
    reset = 1'b1;
    #1;
    check_all_clear("midrst");
    tick();
    reset = 1'b0;
    load_image(0);
    check("reload_gray_ready", 32'(gray_ready), 32'd1);

    // Full in-order pass; last write coincides with finish.
    for (int a = 0; a < NPIX; a++) write_px(a, a == NPIX - 1);
    check("ord_wr_cnt",     32'(wr_cnt),     32'd16384);
    check("ord_done",       32'(done),       32'd1);
    check("ord_seq_err",    32'(seq_err),    32'd0);
    check("ord_incomplete", 32'(incomplete), 32'd0);
    check("ord_proto_err",  32'(proto_err),  32'd0);
    readback("res_0081", 16'h0081);
    check("res_0081_lit", 32'(res_data), 32'h7E);
    readback("res_0003", 3);
    readback("res_3fff", 16'h3FFF);
    gray_read("done_gray_0042", 1'b1, 16'h0042, 8'h42);

    // Write after DONE is rejected.
    lbp_valid = 1'b1; lbp_addr = 14'h0081; lbp_data = 8'h11;
    tick();
    lbp_valid = 1'b0;
    check("post_wr_cnt",    32'(wr_cnt),    32'd16384);
    check("post_proto_err", 32'(proto_err), 32'd1);
    tick();
    readback("post_res_0081", 16'h0081);

    // Fresh image, skip address 5, finish on a separate cycle.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load_image(0);
    for (int a = 0; a < NPIX; a++) if (a != 5) write_px(a, 1'b0);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    check("skip_wr_cnt",     32'(wr_cnt),     32'd16383);
    check("skip_seq_err",    32'(seq_err),    32'd1);
    check("skip_incomplete", 32'(incomplete), 32'd1);
    check("skip_done",       32'(done),       32'd1);
    check("skip_proto_err",  32'(proto_err),  32'd0);
    readback("skip_res_0005", 5);
    readback("skip_res_0006", 6);

    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $error("FAIL sb_leftover: got %0d entries, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
